// File: rtl/matrix_addr_gen.sv
// Matrix address generator: walks a ROWS x COLS row-major matrix in one of four
// traversal orders, emitting one registered linear address per enabled cycle.
module matrix_addr_gen #(
    parameter  int ROWS = 3,
    parameter  int COLS = 3,
    localparam int AW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          loop,
    input  logic          ena,
    output logic [AW-1:0] addr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          valid,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_ROW, M_COL, M_ROW_REV, M_COL_REV} mode_e;

    localparam logic [RW-1:0] RMAX   = RW'(ROWS - 1);
    localparam logic [CW-1:0] CMAX   = CW'(COLS - 1);
    localparam logic [AW-1:0] NCOLS  = AW'(COLS);

    state_e          state_q, state_d;
    mode_e           mode_q,  mode_d;
    logic            loop_q,  loop_d;
    logic [RW-1:0]   row_q,   row_d;
    logic [CW-1:0]   col_q,   col_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            last_q,  last_d;
    logic [RW-1:0]   step_row;
    logic [CW-1:0]   step_col;

    function automatic logic is_fwd(input mode_e m);
        return (m == M_ROW) || (m == M_COL);
    endfunction

    // Forward orders end at the bottom-right corner, reverse orders at the origin.
    function automatic logic is_final(input mode_e m, input logic [RW-1:0] r,
                                      input logic [CW-1:0] c);
        if (is_fwd(m))
            return (r == RMAX) && (c == CMAX);
        else
            return (r == '0) && (c == '0);
    endfunction

    always_comb begin
        step_row = row_q;
        step_col = col_q;
        unique case (mode_q)
            M_ROW: begin
                if (col_q == CMAX) begin
                    step_col = '0;
                    step_row = row_q + RW'(1);
                end else begin
                    step_col = col_q + CW'(1);
                end
            end
            M_COL: begin
                if (row_q == RMAX) begin
                    step_row = '0;
                    step_col = col_q + CW'(1);
                end else begin
                    step_row = row_q + RW'(1);
                end
            end
            M_ROW_REV: begin
                if (col_q == '0) begin
                    step_col = CMAX;
                    step_row = row_q - RW'(1);
                end else begin
                    step_col = col_q - CW'(1);
                end
            end
            M_COL_REV: begin
                if (row_q == '0) begin
                    step_row = RMAX;
                    step_col = col_q - CW'(1);
                end else begin
                    step_row = row_q - RW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        loop_d  = loop_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                row_d  = '0;
                col_d  = '0;
                last_d = 1'b0;
                if (start) begin
                    mode_d  = mode_e'(mode);
                    loop_d  = loop;
                    row_d   = is_fwd(mode_e'(mode)) ? '0 : RMAX;
                    col_d   = is_fwd(mode_e'(mode)) ? '0 : CMAX;
                    last_d  = is_final(mode_e'(mode), row_d, col_d);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ena) begin
                    if (last_q && !loop_q) begin
                        row_d   = '0;
                        col_d   = '0;
                        last_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        if (last_q) begin
                            row_d = is_fwd(mode_q) ? '0 : RMAX;
                            col_d = is_fwd(mode_q) ? '0 : CMAX;
                        end else begin
                            row_d = step_row;
                            col_d = step_col;
                        end
                        last_d = is_final(mode_q, row_d, col_d);
                    end
                end
            end
            S_DONE: begin
                row_d   = '0;
                col_d   = '0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        addr_d = AW'(row_d) * NCOLS + AW'(col_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_ROW;
            loop_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign addr  = addr_q;
    assign row   = row_q;
    assign col   = col_q;
    assign last  = last_q;
    assign valid = (state_q == S_RUN);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);

endmodule
